// File: rtl/hazard_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard inputs and the stall/flush/enable outputs.
// The master modport is the pipeline side. The slave modport is the controller.
interface hazard_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_redirect;
  logic       mem_req;
  logic       mem_ready;
  logic       stall;
  logic       flush;
  logic       pc_write;
  logic       if_id_write;
  logic       id_ex_bubble;
  logic [1:0] fsm_state;

  // Handshake: a memory access is held while mem_req=1 and mem_ready=0.
  // It completes in the cycle where mem_req=1 and mem_ready=1.
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_redirect, mem_req, mem_ready,
    input  stall, flush, pc_write, if_id_write, id_ex_bubble, fsm_state
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_redirect, mem_req, mem_ready,
    output stall, flush, pc_write, if_id_write, id_ex_bubble, fsm_state
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, redirect flush window, memory-wait freeze.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic clk,
  input  logic rst,
  hazard_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] perf_stall_cycles,
  output logic [CNT_WIDTH-1:0] perf_flush_events,
  output logic [CNT_WIDTH-1:0] perf_mem_wait_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FLUSH    = 2'b10
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t     state, state_next;
  logic [2:0] flush_cnt, cnt_next;
  logic       mem_hold, load_use, hold;
  logic       stall, flush, pc_write, if_id_write, id_ex_bubble;
  logic       redirect_taken;

  assign mem_hold = hz.mem_req & ~hz.mem_ready;
  assign load_use = hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                    ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                     (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));

  // In MEM_WAIT only mem_ready matters; the access stays open until it completes.
  assign hold = (state == ST_MEM_WAIT) ? ~hz.mem_ready : mem_hold;

  always_comb begin
    stall          = 1'b0;
    flush          = 1'b0;
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    id_ex_bubble   = 1'b0;
    redirect_taken = 1'b0;
    state_next     = state;
    cnt_next       = flush_cnt;
    if (rst) begin
      flush        = 1'b1;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      state_next   = ST_RUN;
      cnt_next     = 3'd0;
    end else begin
      case (state)
        ST_RUN, ST_MEM_WAIT: begin
          if (hold) begin
            stall       = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            state_next  = ST_MEM_WAIT;
          end else if (hz.ex_redirect) begin
            flush          = 1'b1;
            id_ex_bubble   = 1'b1;
            redirect_taken = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_next = ST_FLUSH;
              cnt_next   = FLUSH_INIT;
            end else begin
              state_next = ST_RUN;
            end
          end else begin
            if (load_use) begin
              stall        = 1'b1;
              pc_write     = 1'b0;
              if_id_write  = 1'b0;
              id_ex_bubble = 1'b1;
            end
            state_next = ST_RUN;
          end
        end
        ST_FLUSH: begin
          flush        = 1'b1;
          id_ex_bubble = 1'b1;
          // A memory wait pauses the flush window without consuming a count.
          if (mem_hold) begin
            stall       = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
          end else if (flush_cnt <= 3'd1) begin
            state_next = ST_RUN;
            cnt_next   = 3'd0;
          end else begin
            cnt_next = flush_cnt - 3'd1;
          end
        end
        default: begin
          state_next = ST_RUN;
          cnt_next   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= 3'd0;
    end else begin
      state     <= state_next;
      flush_cnt <= cnt_next;
    end
  end

  assign hz.stall        = stall;
  assign hz.flush        = flush;
  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.fsm_state    = rst ? 2'b00 : state;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles    <= '0;
      perf_flush_events    <= '0;
      perf_mem_wait_cycles <= '0;
    end else begin
      if (stall && !(&perf_stall_cycles))
        perf_stall_cycles <= perf_stall_cycles + CNT_WIDTH'(1);
      if (redirect_taken && !(&perf_flush_events))
        perf_flush_events <= perf_flush_events + CNT_WIDTH'(1);
      if ((state == ST_MEM_WAIT) && !hz.mem_ready && !(&perf_mem_wait_cycles))
        perf_mem_wait_cycles <= perf_mem_wait_cycles + CNT_WIDTH'(1);
    end
  end
`endif

endmodule
